nonce_result_scanner: RTL and testbench
=======================================

NONCE_RESULT_SCANNER -- requirements
Module: nonce_result_scanner

Interface
REQ-001 Parameter NUM_NONCES, default 16: number of per-nonce hash words to scan (legal range 1..256).
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 Port start, input, 1: level-sampled request to begin a scan; accepted only in IDLE.
REQ-005 Port hash_addr, input, 16: memory address of the nonce-0 hash word; sampled on accept.
REQ-006 Port result_addr, input, 16: base address of the 2-word result record; sampled on accept.
REQ-007 Port target, input, 32: unsigned difficulty threshold; sampled on accept.
REQ-008 Port busy, output, 1: high from accept through the cycle before done.
REQ-009 Port done, output, 1: one-cycle pulse when the scan and record write complete.
REQ-010 Port found, output, 1: at least one hash word < target in the last scan; held until next accept.
REQ-011 Port best_nonce, output, 8: index of the smallest hash word in the last scan; held.
REQ-012 Port min_hash, output, 32: smallest hash word in the last scan; held.
REQ-013 Port mem_clk, output, 1: equals clk.
REQ-014 Port mem_we, output, 1: memory write enable, registered.
REQ-015 Port mem_addr, output, 16: memory address, registered.
REQ-016 Port mem_write_data, output, 32: write data, registered.
REQ-017 Port mem_read_data, input, 32: read data for the address registered on the previous edge.

Function
REQ-018 The FSM SHALL have the states IDLE, PRIME, SCAN, WR0, WR1 and FIN.
- IDLE: start=1 -> latch inputs; mem_addr<=hash_addr; mem_we<=0; idx<=0; min<=32'hFFFFFFFF; best<=0; hit<=0; go to PRIME.
- PRIME: mem_addr<=hash_addr+1; go to SCAN.
- SCAN: each cycle consume mem_read_data as word idx, compare, idx<=idx+1; issue next address while requests remain.
- SCAN, after word NUM_NONCES-1 is consumed: go to WR0.
- WR0: mem_we<=1; mem_addr<=result_addr; mem_write_data<=min; go to WR1.
- WR1: mem_addr<=result_addr+1; mem_write_data<={hit,23'b0,best}; go to FIN.
- FIN: mem_we<=0; done<=1 for one cycle; update found/best_nonce/min_hash; go to IDLE.
REQ-019 The block SHALL stream one word per cycle after PRIME; total latency from accept to done = NUM_NONCES+4 cycles.
REQ-020 A word SHALL replace the running minimum only when it is strictly less (unsigned), so ties keep the lowest index.
REQ-021 hit SHALL be set when any word < target; word == target SHALL NOT count as a hit.
REQ-022 The block SHALL ignore start outside IDLE; start held high after FIN SHALL begin a new scan from IDLE.
REQ-023 Address arithmetic SHALL be modulo 2^16 (wrap from 16'hFFFF to 16'h0000 without error).
REQ-024 With NUM_NONCES=1, SCAN SHALL last exactly one cycle.
REQ-025 The block SHALL NOT assert mem_we outside WR0/WR1.

Reset
REQ-026 When reset_n=0, regardless of clk, the block SHALL enter IDLE with busy=0, done=0, found=0, best_nonce=0, min_hash=32'hFFFFFFFF, mem_we=0, mem_addr=0 and mem_write_data=0.
REQ-027 A reset asserted mid-scan or mid-write SHALL abort the scan with no further memory writes; the record may be partially written.

Structure
REQ-028 A shared package SHALL hold the state enum, the default NUM_NONCES, and the MIN_INIT=32'hFFFFFFFF constant.
REQ-029 The compare/update SHALL be one sub-module, nonce_min_tracker, which is a registered running-min with index and hit flag and a clear input.

Verification
REQ-030 The bench SHALL cover these scenarios:
- Ascending words 0x10..0x1F, target=0x15 -> found=1, best_nonce=0, min_hash=0x10; record 0x00000010, 0x80000000.
- All words 0xFFFFFFF0, target=0x1000 -> found=0, best_nonce=0, min_hash=0xFFFFFFF0; record word1=0x00000000.
- Words equal 0x50 at indices 3 and 9 (others 0x90), target=0x50 -> found=0, best_nonce=3, min_hash=0x50.
- hash_addr=0xFFFE, NUM_NONCES=16 -> reads 0xFFFE, 0xFFFF, 0x0000..0x000D; done exactly 20 cycles after accept.
- reset_n pulsed low in SCAN at idx=7 -> IDLE next cycle, all outputs at reset values, no mem_we pulse afterwards.
- start asserted while busy -> ignored; a single done pulse; the second scan starts only after FIN.

Source files
------------

// File: rtl/nonce_result_scanner_pkg.sv
// rtl/nonce_result_scanner_pkg.sv - shared types and constants for the nonce result scanner
//
// Purpose: FSM state encoding, default scan length, running-min seed value
//          and the result-record word-1 packing helper.
// Ports:   none (package).

package nonce_result_scanner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_SCAN  = 3'd2,
    ST_WR0   = 3'd3,
    ST_WR1   = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

  localparam int          NUM_NONCES_DEFAULT = 16;
  localparam logic [31:0] MIN_INIT           = 32'hFFFF_FFFF;

  // Second record word: hit flag in bit 31, winning index in the low byte.
  function automatic logic [31:0] pack_record1(input logic hit, input logic [7:0] best);
    return {hit, 23'b0, best};
  endfunction

endpackage

// File: rtl/nonce_min_tracker.sv
// rtl/nonce_min_tracker.sv - registered running minimum with index and hit flag
//
// Purpose: tracks the smallest word seen since the last clear, the index at
//          which it was first seen, and whether any word was below target.
// Ports:   clk, reset_n      clock, async active-low reset
//          clear_i           reseed min/best/hit (has priority over valid_i)
//          valid_i           word_i/idx_i carry a word to fold in this cycle
//          word_i, idx_i     candidate word and its nonce index
//          target_i          unsigned threshold for the hit flag
//          min_o, best_o     running minimum and its index
//          hit_o             sticky: some word was strictly below target

module nonce_min_tracker
  import nonce_result_scanner_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [31:0] word_i,
  input  logic [7:0]  idx_i,
  input  logic [31:0] target_i,
  output logic [31:0] min_o,
  output logic [7:0]  best_o,
  output logic        hit_o
);

  logic [31:0] min_q, min_d;
  logic [7:0]  best_q, best_d;
  logic        hit_q, hit_d;

  always_comb begin
    min_d  = min_q;
    best_d = best_q;
    hit_d  = hit_q;
    if (clear_i) begin
      min_d  = MIN_INIT;
      best_d = 8'd0;
      hit_d  = 1'b0;
    end else if (valid_i) begin
      // Strictly-less keeps the earliest index on ties.
      if (word_i < min_q) begin
        min_d  = word_i;
        best_d = idx_i;
      end
      if (word_i < target_i) begin
        hit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min_q  <= MIN_INIT;
      best_q <= 8'd0;
      hit_q  <= 1'b0;
    end else begin
      min_q  <= min_d;
      best_q <= best_d;
      hit_q  <= hit_d;
    end
  end

  assign min_o  = min_q;
  assign best_o = best_q;
  assign hit_o  = hit_q;

endmodule

// File: rtl/nonce_result_scanner.sv
// rtl/nonce_result_scanner.sv - scans per-nonce hash words for the minimum and writes a result record
//
// Purpose: reads NUM_NONCES consecutive words from a synchronous memory,
//          finds the smallest (lowest index on ties) and whether any is
//          below target, writes a 2-word record, then pulses done.
// Ports:   clk, reset_n                 clock, async active-low reset
//          start                        scan request, sampled only in IDLE
//          hash_addr, result_addr       word-0 address, record base address
//          target                       unsigned hit threshold
//          busy, done                   in-progress level, completion pulse
//          found, best_nonce, min_hash  results of the last completed scan
//          mem_clk, mem_we, mem_addr,
//          mem_write_data, mem_read_data  synchronous memory port

module nonce_result_scanner
  import nonce_result_scanner_pkg::*;
#(
  parameter int NUM_NONCES = NUM_NONCES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] hash_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [7:0]  best_nonce,
  output logic [31:0] min_hash,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [7:0] LAST_IDX  = 8'(NUM_NONCES - 1);
  localparam logic [8:0] REQ_LIMIT = 9'(NUM_NONCES);

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] result_addr_q, result_addr_d;
  logic [31:0] target_q, target_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic        found_q, found_d;
  logic [7:0]  best_q, best_d;
  logic [31:0] min_q, min_d;

  logic        accept;
  logic [31:0] trk_min;
  logic [7:0]  trk_best;
  logic        trk_hit;

  assign accept = (state_q == ST_IDLE) && start;

  nonce_min_tracker u_tracker (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (accept),
    .valid_i  (state_q == ST_SCAN),
    .word_i   (mem_read_data),
    .idx_i    (idx_q),
    .target_i (target_q),
    .min_o    (trk_min),
    .best_o   (trk_best),
    .hit_o    (trk_hit)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    result_addr_d = result_addr_q;
    target_d      = target_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    done_d        = 1'b0;
    found_d       = found_q;
    best_d        = best_q;
    min_d         = min_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          result_addr_d = result_addr;
          target_d      = target;
          mem_addr_d    = hash_addr;
          mem_we_d      = 1'b0;
          idx_d         = 8'd0;
          found_d       = 1'b0;
          state_d       = ST_PRIME;
        end
      end
      ST_PRIME: begin
        // Word 0 address is already with the memory; queue word 1.
        mem_addr_d = mem_addr_q + 16'd1;
        state_d    = ST_SCAN;
      end
      ST_SCAN: begin
        idx_d = idx_q + 8'd1;
        // Two requests are always in flight ahead of the word being consumed.
        if (({1'b0, idx_q} + 9'd2) < REQ_LIMIT) begin
          mem_addr_d = mem_addr_q + 16'd1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_WR0;
        end
      end
      ST_WR0: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = result_addr_q;
        mem_wdata_d = trk_min;
        state_d     = ST_WR1;
      end
      ST_WR1: begin
        mem_addr_d  = result_addr_q + 16'd1;
        mem_wdata_d = pack_record1(trk_hit, trk_best);
        state_d     = ST_FIN;
      end
      ST_FIN: begin
        mem_we_d = 1'b0;
        done_d   = 1'b1;
        found_d  = trk_hit;
        best_d   = trk_best;
        min_d    = trk_min;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= 8'd0;
      result_addr_q <= 16'd0;
      target_q      <= 32'd0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 16'd0;
      mem_wdata_q   <= 32'd0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      best_q        <= 8'd0;
      min_q         <= MIN_INIT;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      result_addr_q <= result_addr_d;
      target_q      <= target_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      done_q        <= done_d;
      found_q       <= found_d;
      best_q        <= best_d;
      min_q         <= min_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign found          = found_q;
  assign best_nonce     = best_q;
  assign min_hash       = min_q;
  assign mem_clk        = clk;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_nonce_result_scanner.sv
// tb/tb_nonce_result_scanner.sv - scoreboard bench for nonce_result_scanner

module tb_nonce_result_scanner;

  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] hash_addr;
  logic [15:0] result_addr;
  logic [31:0] target;
  logic        busy;
  logic        done;
  logic        found;
  logic [7:0]  best_nonce;
  logic [31:0] min_hash;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic        prog_we;
  logic [15:0] prog_addr;
  logic [31:0] prog_data;
  logic [31:0] mem [0:65535];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int we_cycles = 0;
  int done_count = 0;

  typedef struct {
    logic        found;
    logic [7:0]  best;
    logic [31:0] minv;
    logic [15:0] res;
    logic [31:0] rec1;
    int          acc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  nonce_result_scanner #(.NUM_NONCES(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .hash_addr      (hash_addr),
    .result_addr    (result_addr),
    .target         (target),
    .busy           (busy),
    .done           (done),
    .found          (found),
    .best_nonce     (best_nonce),
    .min_hash       (min_hash),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always @(posedge mem_clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
    else if (mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Monitor: pops one expectation per done pulse.
  initial begin
    exp_t e;
    logic [15:0] r1;
    forever begin
      @(negedge clk);
      if (mem_we) we_cycles++;
      if (done) begin
        done_count++;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_done: got done=1 with no scan pending, required done=0");
        end else begin
          e = sb.pop_front();
          r1 = e.res + 16'd1;
          chk("found", {31'b0, found}, {31'b0, e.found});
          chk("best_nonce", {24'b0, best_nonce}, {24'b0, e.best});
          chk("min_hash", min_hash, e.minv);
          chk("record_word0", mem[e.res], e.minv);
          chk("record_word1", mem[r1], e.rec1);
          chk("latency", 32'(cyc - e.acc), 32'd20);
        end
      end
    end
  end

  task automatic prog(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    prog_addr = a;
    prog_data = d;
    prog_we = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic wait_accept(output int acc, output bit ok);
    ok = 1'b0;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (busy) begin
        acc = cyc;
        ok = 1'b1;
        return;
      end
    end
    n_checks++;
    $display("FAIL accept_timeout: got busy=0 after 50 cycles, required busy=1");
  endtask

  task automatic wait_done(input int want);
    for (int i = 0; i < 100; i++) begin
      if (done_count >= want) return;
      @(negedge clk);
      #1;
    end
    n_checks++;
    $display("FAIL done_timeout: got %0d done pulses, required %0d", done_count, want);
  endtask

  task automatic run_scan(input logic [15:0] h, input logic [15:0] r, input logic [31:0] t,
                          input logic f, input logic [7:0] b, input logic [31:0] m,
                          input bit check_addr);
    int acc;
    bit ok;
    exp_t e;
    int want;
    logic [15:0] a;
    prog(r, SENT);
    prog(r + 16'd1, SENT);
    @(negedge clk);
    hash_addr = h;
    result_addr = r;
    target = t;
    start = 1'b1;
    want = done_count + 1;
    wait_accept(acc, ok);
    start = 1'b0;
    if (ok) begin
      e.found = f;
      e.best = b;
      e.minv = m;
      e.res = r;
      e.rec1 = {f, 23'b0, b};
      e.acc = acc;
      sb.push_back(e);
      if (check_addr) begin
        a = h;
        for (int k = 0; k < 16; k++) begin
          chk("read_addr", {16'b0, mem_addr}, {16'b0, a});
          a = a + 16'd1;
          @(posedge clk);
          #1;
        end
      end
      wait_done(want);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_found", {31'b0, found}, 32'd0);
    chk("rst_best", {24'b0, best_nonce}, 32'd0);
    chk("rst_min", min_hash, 32'hFFFF_FFFF);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1);
  end

  initial begin
    int acc_a;
    bit ok;
    int we_snap;
    int dc_snap;
    exp_t e;
    logic [15:0] a;

    reset_n = 1'b0;
    start = 1'b0;
    hash_addr = 16'd0;
    result_addr = 16'd0;
    target = 32'd0;
    prog_we = 1'b0;
    prog_addr = 16'd0;
    prog_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();

    // Memory images, programmed while reset is held.
    for (int k = 0; k < 16; k++) prog(16'h0100 + 16'(k), 32'h10 + 32'(k));
    for (int k = 0; k < 16; k++) prog(16'h0400 + 16'(k), 32'hFFFF_FFF0);
    for (int k = 0; k < 16; k++) prog(16'h0200 + 16'(k), (k == 3 || k == 9) ? 32'h50 : 32'h90);
    for (int k = 0; k < 16; k++) prog(16'h0300 + 16'(k), (k == 5 || k == 12) ? 32'h20 : 32'h30);
    a = 16'hFFFE;
    for (int k = 0; k < 16; k++) begin
      prog(a, (k == 13) ? 32'h7 : 32'h1000 + 32'(k));
      a = a + 16'd1;
    end

    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_scan(16'h0100, 16'h4000, 32'h15, 1'b1, 8'd0, 32'h10, 1'b0);
    run_scan(16'h0400, 16'h4002, 32'h1000, 1'b0, 8'd0, 32'hFFFF_FFF0, 1'b0);
    run_scan(16'h0200, 16'h4004, 32'h50, 1'b0, 8'd3, 32'h50, 1'b0);
    run_scan(16'h0300, 16'h4006, 32'h21, 1'b1, 8'd5, 32'h20, 1'b0);
    run_scan(16'hFFFE, 16'h4008, 32'h8, 1'b1, 8'd13, 32'h7, 1'b1);

    // Abort mid-scan with reset at idx=7.
    prog(16'h4010, SENT);
    prog(16'h4011, SENT);
    @(negedge clk);
    hash_addr = 16'h0100;
    result_addr = 16'h4010;
    target = 32'h15;
    start = 1'b1;
    wait_accept(acc_a, ok);
    start = 1'b0;
    if (ok) begin
      repeat (8) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check_reset_outputs();
      we_snap = we_cycles;
      dc_snap = done_count;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      chk("abort_no_write", 32'(we_cycles), 32'(we_snap));
      chk("abort_no_done", 32'(done_count), 32'(dc_snap));
      chk("abort_rec0", mem[16'h4010], SENT);
      chk("abort_rec1", mem[16'h4011], SENT);
      chk("abort_idle", {31'b0, busy}, 32'd0);
    end

    // start held high across a whole scan with changing inputs.
    prog(16'h4020, SENT);
    prog(16'h4021, SENT);
    prog(16'h4022, SENT);
    prog(16'h4023, SENT);
    @(negedge clk);
    hash_addr = 16'h0100;
    result_addr = 16'h4020;
    target = 32'h15;
    start = 1'b1;
    wait_accept(acc_a, ok);
    if (ok) begin
      e.found = 1'b1;
      e.best = 8'd0;
      e.minv = 32'h10;
      e.res = 16'h4020;
      e.rec1 = 32'h8000_0000;
      e.acc = acc_a;
      sb.push_back(e);
      hash_addr = 16'h0200;
      result_addr = 16'h4022;
      target = 32'h50;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        #1;
        if (done) begin
          ok = 1'b1;
          break;
        end
      end
      chk("held_first_done_seen", {31'b0, ok}, 32'd1);
      if (ok) begin
        chk("held_busy_at_done", {31'b0, busy}, 32'd0);
        e.found = 1'b0;
        e.best = 8'd3;
        e.minv = 32'h50;
        e.res = 16'h4022;
        e.rec1 = 32'h0000_0003;
        e.acc = cyc + 1;
        sb.push_back(e);
        dc_snap = done_count;
        @(posedge clk);
        #1;
        chk("held_restart_after_fin", {31'b0, busy}, 32'd1);
        chk("held_single_done_pulse", {31'b0, done}, 32'd0);
        start = 1'b0;
        wait_done(dc_snap + 1);
      end
    end
    start = 1'b0;

    repeat (5) @(negedge clk);
    #1;
    chk("total_done_pulses", 32'(done_count), 32'd7);
    chk("total_we_cycles", 32'(we_cycles), 32'd14);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
